// File: rtl/alu_uart_pkg.sv
// alu_uart_pkg: shared byte width, sequencer state encoding and
// status-byte bit layout for the UART <-> ALU sequencer.
package alu_uart_pkg;

   localparam int NB_DBIT_DFLT = 8;

   localparam logic [2:0] ST_GET_A   = 3'd0;
   localparam logic [2:0] ST_GET_B   = 3'd1;
   localparam logic [2:0] ST_GET_OP  = 3'd2;
   localparam logic [2:0] ST_EXEC    = 3'd3;
   localparam logic [2:0] ST_SEND    = 3'd4;
   localparam logic [2:0] ST_WAIT_TX = 3'd5;
   localparam logic [2:0] ST_SEND_ST = 3'd6;
   localparam logic [2:0] ST_WAIT_ST = 3'd7;

   // Status flag offsets, counted down from the byte MSB.
   localparam int STB_ZERO = 0;
   localparam int STB_SIGN = 1;
   localparam int STB_TMO  = 2;
   localparam int STB_DROP = 3;

endpackage

// File: rtl/alu_seq_timeout.sv
// alu_seq_timeout: inter-byte watchdog counter with clear/enable;
// o_expire is high while enabled and the count sits on its last value.
module alu_seq_timeout #(
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

   logic [CW-1:0] cnt;

   assign o_expire = i_en && (cnt == LAST);

   // Count idle cycles between bytes; clear has priority.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         cnt <= '0;
      end else if (i_clr) begin
         cnt <= '0;
      end else if (i_en) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: collects A/B/opcode bytes, strobes the ALU and sends
// the result. ALU_SEQ_STATUS_EN adds a trailing status byte.
module alu_seq_ctrl
   import alu_uart_pkg::*;
#(
   parameter int NB_DBIT     = NB_DBIT_DFLT,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [NB_DBIT-1:0] i_rx_data,
   input  logic               i_rx_done,
   input  logic [NB_DBIT-1:0] i_alu_result,
   input  logic               i_tx_done,
   output logic [NB_DBIT-1:0] o_a,
   output logic [NB_DBIT-1:0] o_b,
   output logic [NB_DBIT-1:0] o_op,
   output logic               o_alu_valid,
   output logic [NB_DBIT-1:0] o_tx_data,
   output logic               o_tx_start,
   output logic               o_busy,
   output logic               o_timeout,
   output logic               o_drop
);

   logic [2:0] state;
   logic [2:0] state_nx;
   logic       rx_state;
   logic       rx_drop;
   logic       tmo_en;
   logic       tmo_clr;
   logic       tmo_exp;
   logic       tmo_hit;
   logic       st_launch;

   assign rx_state = (state == ST_GET_A) || (state == ST_GET_B) ||
                     (state == ST_GET_OP);
   assign rx_drop  = i_rx_done && !rx_state;
   assign tmo_en   = (state == ST_GET_B) || (state == ST_GET_OP);
   assign tmo_clr  = !tmo_en || i_rx_done || tmo_exp;
   // A byte arriving on the expiry cycle wins over the timeout.
   assign tmo_hit  = tmo_exp && !i_rx_done;

   alu_seq_timeout #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_tmo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clr   (tmo_clr),
      .i_en    (tmo_en),
      .o_expire(tmo_exp)
   );

   // Next-state selection for the frame sequencer.
   always_comb begin
      state_nx = state;
      unique case (state)
         ST_GET_A:   if (i_rx_done) state_nx = ST_GET_B;
         ST_GET_B:   if (i_rx_done) state_nx = ST_GET_OP;
                     else if (tmo_exp) state_nx = ST_GET_A;
         ST_GET_OP:  if (i_rx_done) state_nx = ST_EXEC;
                     else if (tmo_exp) state_nx = ST_GET_A;
         ST_EXEC:    state_nx = ST_SEND;
         ST_SEND:    state_nx = ST_WAIT_TX;
`ifdef ALU_SEQ_STATUS_EN
         ST_WAIT_TX: if (i_tx_done) state_nx = ST_SEND_ST;
         ST_SEND_ST: state_nx = ST_WAIT_ST;
         ST_WAIT_ST: if (i_tx_done) state_nx = ST_GET_A;
`else
         ST_WAIT_TX: if (i_tx_done) state_nx = ST_GET_A;
`endif
         default:    state_nx = ST_GET_A;
      endcase
   end

`ifdef ALU_SEQ_STATUS_EN
   logic               stk_tmo;
   logic               stk_drop;
   logic [NB_DBIT-1:0] status;

   assign st_launch = (state == ST_WAIT_TX) && i_tx_done;

   // Status byte built from the result byte still held in o_tx_data.
   always_comb begin
      status = '0;
      status[NB_DBIT-1-STB_ZERO] = (o_tx_data == '0);
      status[NB_DBIT-1-STB_SIGN] = o_tx_data[NB_DBIT-1];
      status[NB_DBIT-1-STB_TMO]  = stk_tmo;
      status[NB_DBIT-1-STB_DROP] = stk_drop;
   end

   // Sticky event flags, cleared once the status byte is out.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         stk_tmo  <= 1'b0;
         stk_drop <= 1'b0;
      end else begin
         if ((state == ST_WAIT_ST) && i_tx_done) begin
            stk_tmo  <= 1'b0;
            stk_drop <= 1'b0;
         end
         if (tmo_hit) stk_tmo <= 1'b1;
         if (rx_drop) stk_drop <= 1'b1;
      end
   end
`else
   assign st_launch = 1'b0;
`endif

   // State and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state       <= ST_GET_A;
         o_a         <= '0;
         o_b         <= '0;
         o_op        <= '0;
         o_alu_valid <= 1'b0;
         o_tx_data   <= '0;
         o_tx_start  <= 1'b0;
         o_busy      <= 1'b0;
         o_timeout   <= 1'b0;
         o_drop      <= 1'b0;
      end else begin
         state       <= state_nx;
         o_busy      <= (state_nx != ST_GET_A);
         o_alu_valid <= (state == ST_GET_OP) && i_rx_done;
         o_tx_start  <= (state == ST_EXEC) || st_launch;
         o_timeout   <= tmo_hit;
         o_drop      <= rx_drop;
         if ((state == ST_GET_A) && i_rx_done) o_a <= i_rx_data;
         if ((state == ST_GET_B) && i_rx_done) o_b <= i_rx_data;
         if ((state == ST_GET_OP) && i_rx_done) o_op <= i_rx_data;
         if (state == ST_EXEC) o_tx_data <= i_alu_result;
`ifdef ALU_SEQ_STATUS_EN
         if (st_launch) o_tx_data <= status;
`endif
      end
   end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Sequencer between the UART receiver, the ALU and the UART transmitter.
- Collects three received bytes (operand A, operand B, opcode) and presents them to the ALU.
- Issues an ALU-valid strobe, captures the result and launches it through the transmitter with a start/done handshake.
- Guards the byte sequence with an inter-byte timeout so a lost byte cannot desynchronise the frame.

Parameters:
NB_DBIT, 8, data byte / operand / result width.
TIMEOUT_CYC, 100000, max clock cycles allowed between bytes of one frame; minimum value 2.

Ports:
i_clk  in  1  system clock.
i_rst  in  1  asynchronous active-low reset.
i_rx_data  in  NB_DBIT  byte from UART receiver, valid when i_rx_done=1.
i_rx_done  in  1  one-cycle pulse, new byte available.
i_alu_result  in  NB_DBIT  combinational ALU result for current o_a/o_b/o_op.
i_tx_done  in  1  one-cycle pulse, transmitter finished current byte.
o_a  out  NB_DBIT  operand A, signed.
o_b  out  NB_DBIT  operand B, signed.
o_op  out  NB_DBIT  opcode.
o_alu_valid  out  1  one-cycle pulse, operands/opcode complete.
o_tx_data  out  NB_DBIT  byte to transmit.
o_tx_start  out  1  one-cycle pulse, start transmission.
o_busy  out  1  high in any state other than GET_A.
o_timeout  out  1  one-cycle pulse, frame aborted by timeout.
o_drop  out  1  one-cycle pulse, byte received while not accepting.

Behaviour:
- Reset (i_rst=0, asynchronous): state GET_A; all outputs 0; timeout counter 0.
- States: GET_A, GET_B, GET_OP, EXEC, SEND, WAIT_TX (plus SEND_ST and WAIT_ST only with the optional feature).
- GET_A: on i_rx_done, o_a<=i_rx_data, go to GET_B, clear counter.
- GET_B: on i_rx_done, o_b<=i_rx_data, go to GET_OP, clear counter.
- GET_OP: on i_rx_done, o_op<=i_rx_data, go to EXEC.
- Timeout:
  - The counter increments each cycle in GET_B and GET_OP.
  - If the counter reaches TIMEOUT_CYC-1 with no i_rx_done, return to GET_A and pulse o_timeout.
  - o_a/o_b/o_op hold their last values.
  - If i_rx_done and expiry occur in the same cycle, the byte wins: accept it, no timeout.
  - No timeout applies in GET_A.
- EXEC lasts exactly 1 cycle:
  - o_alu_valid=1 for that cycle.
  - o_tx_data<=i_alu_result, sampled at the end of EXEC.
  - Go to SEND.
- SEND lasts 1 cycle: o_tx_start=1, go to WAIT_TX.
- WAIT_TX: wait indefinitely for i_tx_done, then go to GET_A (or SEND_ST with the feature).
- An i_tx_done received outside WAIT_TX/WAIT_ST is ignored.
- Latency: from the opcode i_rx_done cycle, o_alu_valid appears on the next cycle and o_tx_start on the cycle after that.
- i_rx_done in EXEC/SEND/WAIT_TX/SEND_ST/WAIT_ST: byte discarded, o_drop pulses the next cycle, state unchanged.
- i_rx_done in the same cycle as the WAIT_TX→GET_A transition is dropped; the byte is not captured as A.
- No arithmetic in this block; operands pass through unmodified (signedness is an ALU concern).
- All outputs are registered.

Optional Feature:
Macro ALU_SEQ_STATUS_EN.
- Defined:
  - After WAIT_TX, go to SEND_ST: o_tx_data<={zero, sign, sticky_timeout, sticky_drop, 0...} (MSB first, remaining LSBs zero), o_tx_start pulses, then WAIT_ST waits for i_tx_done, then GET_A.
  - zero = (result==0); sign = result[NB_DBIT-1].
  - Both sticky flags are set by o_timeout/o_drop and cleared after the status byte is sent.
- Undefined: no status byte, no sticky registers, SEND_ST/WAIT_ST absent; the frame ends after one result byte.

Decomposition:
- Shared package alu_uart_pkg: NB_DBIT default; state encoding localparams; status bit positions.
- Counter width is derived as $clog2(TIMEOUT_CYC).
- One natural sub-module: alu_seq_timeout (loadable clear/enable counter with expiry pulse).
- The FSM and output registers stay in alu_seq_ctrl.

Test Plan:
- Normal frame: bytes 0x04, 0x02, 0x08 with rx pulses 12 cycles apart, ALU model returns A+B → o_a=0x04, o_b=0x02, o_op=0x08, o_alu_valid 1 cycle after the third pulse, o_tx_data=0x06 with o_tx_start on the following cycle; after i_tx_done, o_busy=0.
- Timeout: send 0x04 only, TIMEOUT_CYC=16 → o_timeout pulses 16 cycles after that byte, state GET_A; a following 0x05, 0x03, 0x08 frame gives o_tx_data=0x08.
- Drop: during WAIT_TX inject byte 0x55 → o_drop pulses once, o_a unchanged, next frame is correct.
- Reset mid-frame: after A=0x7F and B=0x01, assert i_rst=0 asynchronously between clock edges → all outputs 0 immediately, the next three bytes form a new frame.
- Boundary: i_rx_done coincident with timeout expiry in GET_OP → byte accepted, o_alu_valid asserted, no o_timeout.
- With ALU_SEQ_STATUS_EN: A=0x80, B=0x80, ALU returns 0x00 → result byte 0x00 followed by status byte 0x80 (zero=1, sign=0, flags 0); two o_tx_start pulses, each gated by i_tx_done.
